// File: rtl/axi_id_remap_table.sv
// -----------------------------------------------------------------------------
// axi_id_remap_table
//
// Purpose:
//   Remaps external AXI read IDs (ARID) onto unique internal IDs for the ROB
//   read path. Each row of the table is bound to one external ID, and each
//   column of a row is one outstanding slot for that ID. The internal ID is
//   UID = {row, col}. Every slot keeps the external ID it was allocated for,
//   so frees may arrive in any order. Each free returns a registered response
//   with the restored external ID, or an error if the UID was not in use.
//
// Ports:
//   clk             clock
//   rst             synchronous, active-high reset
//   alloc_valid     allocation request
//   alloc_id        external ID to remap
//   alloc_ready     a slot is available for alloc_id this cycle
//                   (independent of alloc_valid)
//   alloc_uid       granted UID; zero when alloc_ready is low
//   free_valid      release one UID; always accepted
//   free_uid        UID being released
//   free_rsp_valid  registered free response strobe (1-cycle latency)
//   free_rsp_id     external ID restored for the freed UID (0 on error)
//   free_rsp_err    freed UID was not in use or was out of range
//   outstanding     registered count of used slots
//   full            registered flag: every slot of every row is used
// -----------------------------------------------------------------------------
module axi_id_remap_table #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int UID_W   = ROW_W + COL_W,
    localparam int OCC_W   = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [ID_WIDTH-1:0] alloc_id,
    output logic                alloc_ready,
    output logic [UID_W-1:0]    alloc_uid,
    input  logic                free_valid,
    input  logic [UID_W-1:0]    free_uid,
    output logic                free_rsp_valid,
    output logic [ID_WIDTH-1:0] free_rsp_id,
    output logic                free_rsp_err,
    output logic [OCC_W-1:0]    outstanding,
    output logic                full
);

    // ------------------------------------------------------------------
    // Table state
    // ------------------------------------------------------------------
    logic                r_row_bound [NUM_ROWS];
    logic [ID_WIDTH-1:0] r_row_id    [NUM_ROWS];
    logic [NUM_COLS-1:0] r_slot_used [NUM_ROWS];
    logic [ID_WIDTH-1:0] r_tag       [NUM_ROWS][NUM_COLS];

    logic                r_rsp_valid;
    logic [ID_WIDTH-1:0] r_rsp_id;
    logic                r_rsp_err;
    logic [OCC_W-1:0]    r_outstanding;
    logic                r_full;

    // ------------------------------------------------------------------
    // Free decode
    // ------------------------------------------------------------------
    logic [ROW_W-1:0]    w_frow;
    logic [COL_W-1:0]    w_fcol;
    logic                w_free_ok;
    logic [ID_WIDTH-1:0] w_free_tag;

    assign w_frow = free_uid[UID_W-1:COL_W];
    assign w_fcol = free_uid[COL_W-1:0];

    // NOTE: every variable written in an always_comb gets a default first,
    // so no path through the block can leave it unassigned (no latch).
    always_comb begin
        w_free_ok  = 1'b0;
        w_free_tag = '0;
        // The range guard keeps a UID past NUM_ROWS/NUM_COLS (possible when
        // those are not powers of two) from indexing outside the table.
        if (free_valid && (int'(w_frow) < NUM_ROWS) && (int'(w_fcol) < NUM_COLS)) begin
            w_free_ok  = r_slot_used[w_frow][w_fcol];
            w_free_tag = r_tag[w_frow][w_fcol];
        end
    end

    // ------------------------------------------------------------------
    // Row selection: a bound row matching alloc_id wins, otherwise the
    // lowest unbound row. Only registered row_bound is consulted, so a row
    // emptied by a free this cycle is not yet offered as unbound.
    // ------------------------------------------------------------------
    logic             w_hit_found;
    logic [ROW_W-1:0] w_hit_row;
    logic             w_unb_found;
    logic [ROW_W-1:0] w_unb_row;
    logic             w_row_found;
    logic [ROW_W-1:0] w_row;

    always_comb begin
        w_hit_found = 1'b0;
        w_hit_row   = '0;
        w_unb_found = 1'b0;
        w_unb_row   = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!w_hit_found && r_row_bound[i] && (r_row_id[i] == alloc_id)) begin
                w_hit_found = 1'b1;
                w_hit_row   = ROW_W'(i);
            end
            if (!w_unb_found && !r_row_bound[i]) begin
                w_unb_found = 1'b1;
                w_unb_row   = ROW_W'(i);
            end
        end
    end

    assign w_row_found = w_hit_found || w_unb_found;
    assign w_row       = w_hit_found ? w_hit_row : w_unb_row;

    // ------------------------------------------------------------------
    // Column selection: a slot freed this cycle counts as available, so a
    // full row can accept an allocation in the same cycle as a free.
    // ------------------------------------------------------------------
    logic [NUM_COLS-1:0] w_eff_used;
    logic                w_col_found;
    logic [COL_W-1:0]    w_col;

    always_comb begin
        w_eff_used = r_slot_used[w_row];
        if (w_free_ok && (w_frow == w_row)) begin
            w_eff_used[w_fcol] = 1'b0;
        end
        w_col_found = 1'b0;
        w_col       = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!w_col_found && !w_eff_used[c]) begin
                w_col_found = 1'b1;
                w_col       = COL_W'(c);
            end
        end
    end

    logic w_ready;
    logic w_fire;

    assign w_ready     = w_row_found && w_col_found;
    assign w_fire      = alloc_valid && w_ready;
    assign alloc_ready = w_ready;
    assign alloc_uid   = w_ready ? {w_row, w_col} : '0;

    // ------------------------------------------------------------------
    // Row release: the freed row unbinds when its bitmap empties, unless
    // an allocation lands in the same row this cycle.
    // ------------------------------------------------------------------
    logic [NUM_COLS-1:0] w_frow_next;
    logic                w_unbind;

    always_comb begin
        w_frow_next = '0;
        w_unbind    = 1'b0;
        if (w_free_ok) begin
            w_frow_next         = r_slot_used[w_frow];
            w_frow_next[w_fcol] = 1'b0;
            w_unbind            = (w_frow_next == '0) && !(w_fire && (w_row == w_frow));
        end
    end

    logic [OCC_W-1:0] w_occ_next;

    assign w_occ_next = r_outstanding + OCC_W'(w_fire) - OCC_W'(w_free_ok);

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag array is small flop storage, not a RAM, so it is
            // reset along with the rest of the table to keep responses defined.
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_row_bound[i] <= 1'b0;
                r_row_id[i]    <= '0;
                r_slot_used[i] <= '0;
                for (int c = 0; c < NUM_COLS; c++) begin
                    r_tag[i][c] <= '0;
                end
            end
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_err     <= 1'b0;
            r_outstanding <= '0;
            r_full        <= 1'b0;
        end else begin
            // Clear before set: if alloc and free hit the same slot, the
            // later set wins and the slot stays used.
            if (w_free_ok) begin
                r_slot_used[w_frow][w_fcol] <= 1'b0;
            end
            if (w_fire) begin
                r_slot_used[w_row][w_col] <= 1'b1;
                r_tag[w_row][w_col]       <= alloc_id;
                if (!r_row_bound[w_row]) begin
                    r_row_bound[w_row] <= 1'b1;
                    r_row_id[w_row]    <= alloc_id;
                end
            end
            if (w_unbind) begin
                r_row_bound[w_frow] <= 1'b0;
                r_row_id[w_frow]    <= '0;
            end

            // The response tag is read from pre-edge state, so a same-slot
            // re-allocation still returns the old tag.
            r_rsp_valid   <= free_valid;
            r_rsp_id      <= w_free_ok ? w_free_tag : '0;
            r_rsp_err     <= free_valid && !w_free_ok;
            r_outstanding <= w_occ_next;
            r_full        <= (w_occ_next == OCC_W'(NUM_ROWS * NUM_COLS));
        end
    end

    assign free_rsp_valid = r_rsp_valid;
    assign free_rsp_id    = r_rsp_id;
    assign free_rsp_err   = r_rsp_err;
    assign outstanding    = r_outstanding;
    assign full           = r_full;

endmodule

// File: tb/tb_axi_id_remap_table.sv
// -----------------------------------------------------------------------------
// tb_axi_id_remap_table
//
// Directed bench for axi_id_remap_table (4 rows x 4 cols, 4-bit IDs).
// A table model (per-row bound/id, per-slot used/tag arrays) advances at each
// clock edge; a compare process checks every DUT output against it on each
// falling edge once reset has been applied. Directed scenarios additionally
// check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_axi_id_remap_table;

    localparam int IDW = 4;
    localparam int NR  = 4;
    localparam int NC  = 4;
    localparam int UW  = 4;
    localparam int OW  = 5;

    logic           clk;
    logic           rst;
    logic           alloc_valid;
    logic [IDW-1:0] alloc_id;
    logic           alloc_ready;
    logic [UW-1:0]  alloc_uid;
    logic           free_valid;
    logic [UW-1:0]  free_uid;
    logic           free_rsp_valid;
    logic [IDW-1:0] free_rsp_id;
    logic           free_rsp_err;
    logic [OW-1:0]  outstanding;
    logic           full;

    axi_id_remap_table #(
        .ID_WIDTH (IDW),
        .NUM_ROWS (NR),
        .NUM_COLS (NC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_id       (alloc_id),
        .alloc_ready    (alloc_ready),
        .alloc_uid      (alloc_uid),
        .free_valid     (free_valid),
        .free_uid       (free_uid),
        .free_rsp_valid (free_rsp_valid),
        .free_rsp_id    (free_rsp_id),
        .free_rsp_err   (free_rsp_err),
        .outstanding    (outstanding),
        .full           (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Table model
    // ------------------------------------------------------------------
    bit           m_bound [NR];
    int           m_id    [NR];
    bit           m_used  [NR][NC];
    int           m_tag   [NR][NC];
    bit           m_rsp_v;
    int           m_rsp_id;
    bit           m_rsp_err;
    int           m_out;
    bit           m_full;
    bit           cmp_en = 1'b0;

    // Which slot would an allocation of id get right now, given any free
    // presented in the same cycle?
    function automatic void model_pick(input int id, input bit fv, input int fu,
                                       output bit rdy, output int row, output int col);
        int  fr;
        int  fc;
        bit  fok;
        fr  = fu / NC;
        fc  = fu % NC;
        fok = fv && m_used[fr][fc];
        rdy = 1'b0;
        row = -1;
        col = -1;
        for (int r = 0; r < NR; r++)
            if (row < 0 && m_bound[r] && m_id[r] == id) row = r;
        if (row < 0)
            for (int r = 0; r < NR; r++)
                if (row < 0 && !m_bound[r]) row = r;
        if (row >= 0)
            for (int c = 0; c < NC; c++)
                if (col < 0 && (!m_used[row][c] || (fok && fr == row && fc == c))) col = c;
        rdy = (row >= 0) && (col >= 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_bound[r] = 1'b0;
                m_id[r]    = 0;
                for (int c = 0; c < NC; c++) begin
                    m_used[r][c] = 1'b0;
                    m_tag[r][c]  = 0;
                end
            end
            m_rsp_v   = 1'b0;
            m_rsp_id  = 0;
            m_rsp_err = 1'b0;
            m_out     = 0;
            m_full    = 1'b0;
        end else begin
            bit rdy;
            int row;
            int col;
            int fr;
            int fc;
            bit fok;
            bit fire;
            bit empty;
            model_pick(int'(alloc_id), free_valid, int'(free_uid), rdy, row, col);
            fr   = int'(free_uid) / NC;
            fc   = int'(free_uid) % NC;
            fok  = free_valid && m_used[fr][fc];
            fire = alloc_valid && rdy;
            m_rsp_v   = free_valid;
            m_rsp_id  = fok ? m_tag[fr][fc] : 0;
            m_rsp_err = free_valid && !fok;
            if (fok) m_used[fr][fc] = 1'b0;
            if (fire) begin
                m_used[row][col] = 1'b1;
                m_tag[row][col]  = int'(alloc_id);
                m_bound[row]     = 1'b1;
                m_id[row]        = int'(alloc_id);
            end
            if (fok) begin
                empty = 1'b1;
                for (int c = 0; c < NC; c++) if (m_used[fr][c]) empty = 1'b0;
                if (empty) begin
                    m_bound[fr] = 1'b0;
                    m_id[fr]    = 0;
                end
            end
            m_out  = m_out + (fire ? 1 : 0) - (fok ? 1 : 0);
            m_full = (m_out == NR * NC);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            bit rdy;
            int row;
            int col;
            model_pick(int'(alloc_id), free_valid, int'(free_uid), rdy, row, col);
            check("m_alloc_ready", 32'(alloc_ready), 32'(rdy));
            check("m_alloc_uid",   32'(alloc_uid),   rdy ? 32'(row * NC + col) : 32'd0);
            check("m_rsp_valid",   32'(free_rsp_valid), 32'(m_rsp_v));
            check("m_rsp_id",      32'(free_rsp_id),    32'(m_rsp_id));
            check("m_rsp_err",     32'(free_rsp_err),   32'(m_rsp_err));
            check("m_outstanding", 32'(outstanding),    32'(m_out));
            check("m_full",        32'(full),           32'(m_full));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        alloc_id    = '0;
        free_valid  = 1'b0;
        free_uid    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Present an allocation, check the offered UID, and let it fire.
    task automatic alloc_expect(input int id, input int exp_uid, input string name);
        alloc_valid = 1'b1;
        alloc_id    = IDW'(id);
        @(negedge clk);
        check({name, "_ready"}, 32'(alloc_ready), 32'd1);
        check({name, "_uid"},   32'(alloc_uid),   32'(exp_uid));
        step();
        idle();
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        idle();
        step();
        cmp_en = 1'b1;
        do_reset();

        // Reset state.
        @(negedge clk);
        check("rst_outstanding", 32'(outstanding),    32'd0);
        check("rst_full",        32'(full),           32'd0);
        check("rst_rsp_valid",   32'(free_rsp_valid), 32'd0);
        check("rst_ready",       32'(alloc_ready),    32'd1);

        // id 3, id 3, id 5 -> 0x0, 0x1, 0x4.
        step();
        alloc_expect(3, 'h0, "a1");
        alloc_expect(3, 'h1, "a2");
        alloc_expect(5, 'h4, "a3");
        @(negedge clk);
        check("a_outstanding", 32'(outstanding), 32'd3);

        // Fill row 0 with id 3, free 0x2 out of order, re-alloc gets 0x2.
        step();
        do_reset();
        for (int i = 0; i < 4; i++) alloc_expect(3, i, "fill");
        free_valid = 1'b1;
        free_uid   = 4'h2;
        step();
        idle();
        @(negedge clk);
        check("f2_rsp_valid", 32'(free_rsp_valid), 32'd1);
        check("f2_rsp_id",    32'(free_rsp_id),    32'd3);
        check("f2_rsp_err",   32'(free_rsp_err),   32'd0);
        step();
        alloc_expect(3, 'h2, "realloc");

        // Row 0 full; same-cycle free 0x1 and alloc id 3 reuse slot 1.
        alloc_valid = 1'b1;
        alloc_id    = 4'd3;
        free_valid  = 1'b1;
        free_uid    = 4'h1;
        @(negedge clk);
        check("same_ready", 32'(alloc_ready), 32'd1);
        check("same_uid",   32'(alloc_uid),   32'h1);
        step();
        idle();
        @(negedge clk);
        check("same_rsp_id",      32'(free_rsp_id), 32'd3);
        check("same_outstanding", 32'(outstanding), 32'd4);
        alloc_id = 4'd3;
        #1;
        check("same_row_full", 32'(alloc_ready), 32'd0);
        alloc_id = 4'd7;
        #1;
        check("same_row_bound", 32'(alloc_uid), 32'h4);
        step();

        // All rows bound; a free in the same cycle does not unbind a row early.
        do_reset();
        alloc_expect(1, 'h0, "r1");
        alloc_expect(2, 'h4, "r2");
        alloc_expect(3, 'h8, "r3");
        alloc_expect(4, 'hC, "r4");
        alloc_valid = 1'b1;
        alloc_id    = 4'd9;
        @(negedge clk);
        check("norow_ready", 32'(alloc_ready), 32'd0);
        check("norow_uid",   32'(alloc_uid),   32'd0);
        free_valid = 1'b1;
        free_uid   = 4'h8;
        #1;
        check("norow_free_ready", 32'(alloc_ready), 32'd0);
        step();
        free_valid = 1'b0;
        @(negedge clk);
        check("unbound_ready", 32'(alloc_ready),  32'd1);
        check("unbound_uid",   32'(alloc_uid),    32'h8);
        check("unbound_rsp",   32'(free_rsp_id),  32'd3);
        step();
        idle();

        // Erroneous free of an unused slot.
        free_valid = 1'b1;
        free_uid   = 4'h5;
        step();
        idle();
        @(negedge clk);
        check("err_rsp_valid",   32'(free_rsp_valid), 32'd1);
        check("err_rsp_err",     32'(free_rsp_err),   32'd1);
        check("err_rsp_id",      32'(free_rsp_id),    32'd0);
        check("err_outstanding", 32'(outstanding),    32'd4);

        // Freeing the only slot of row 0 unbinds it for a new id.
        step();
        free_valid = 1'b1;
        free_uid   = 4'h0;
        step();
        idle();
        alloc_expect(11, 'h0, "rebind");

        // Fill the whole table: full asserts, nothing more is offered.
        do_reset();
        for (int i = 0; i < NR * NC; i++) alloc_expect(i / NC + 6, i, "all");
        @(negedge clk);
        check("full_flag",        32'(full),        32'd1);
        check("full_outstanding", 32'(outstanding), 32'd16);
        alloc_id = 4'd6;
        #1;
        check("full_ready", 32'(alloc_ready), 32'd0);
        step();
        free_valid = 1'b1;
        free_uid   = 4'hF;
        step();
        idle();
        @(negedge clk);
        check("unfull_flag", 32'(full), 32'd0);
        step();

        // Reset mid-operation discards in-flight UIDs.
        do_reset();
        alloc_expect(2, 'h0, "pre1");
        alloc_expect(2, 'h1, "pre2");
        alloc_expect(4, 'h4, "pre3");
        rst = 1'b1;
        step();
        rst = 1'b0;
        free_valid = 1'b1;
        free_uid   = 4'h0;
        step();
        idle();
        @(negedge clk);
        check("post_rst_err",         32'(free_rsp_err), 32'd1);
        check("post_rst_outstanding", 32'(outstanding),  32'd0);
        check("post_rst_full",        32'(full),         32'd0);
        step();
        alloc_expect(6, 'h0, "post_rst_alloc");

        step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
